// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared codes, preamble patterns and state type for the HDMI period sequencer.
package hdmi_pkg;
  localparam int PRE_LEN = 8;
  localparam int GB_LEN = 2;
  localparam int ISLAND_WAIT = 2;
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  localparam logic [9:0] VGB_CH0 = 10'b1011001100;
  localparam logic [9:0] VGB_CH1 = 10'b0100110011;
  localparam logic [9:0] VGB_CH2 = 10'b1011001100;
  localparam logic [3:0] VIDEO_PREAMBLE = 4'b0001;
  localparam logic [3:0] ISLAND_PREAMBLE = 4'b0101;
  typedef enum logic [2:0] {CTRL, VPRE, VGB, VIDEO, IPRE, ISLAND} state_t;
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       isl;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] ich0;
    logic [9:0] ich1;
    logic [9:0] ich2;
  } stage_t;
  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    return c == 2'b00 ? CTRL_00 : c == 2'b01 ? CTRL_01 : c == 2'b10 ? CTRL_10 : CTRL_11;
  endfunction
endpackage

// File: rtl/tmds_video_encoder.sv
// tmds_video_encoder: DVI 8b/10b video encoder with running disparity; character is combinational, disparity registered.
module tmds_video_encoder (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       clearDisparity,
  input  logic [7:0] videoData,
  output logic [9:0] videoChar
);
  logic [8:0] qm;
  logic [3:0] n1d, n1q;
  logic use_xnor, same;
  logic signed [5:0] bal, disp_q, disp_d;
  function automatic logic [7:0] prefix_xor(input logic [7:0] d);
    logic [7:0] p;
    p[0] = d[0];
    for (int i = 1; i < 8; i++) p[i] = p[i-1] ^ d[i];
    return p;
  endfunction
  // the XNOR chain equals the XOR chain with every odd bit inverted
  always_comb begin
    n1d = 4'($countones(videoData));
    use_xnor = n1d > 4'd4 || (n1d == 4'd4 && !videoData[0]);
    qm = {~use_xnor, prefix_xor(videoData) ^ (use_xnor ? 8'b10101010 : 8'b00000000)};
    n1q = 4'($countones(qm[7:0]));
    bal = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    same = disp_q[5] == bal[5];
    if (disp_q == '0 || bal == '0) begin
      videoChar = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp_d = qm[8] ? disp_q + bal : disp_q - bal;
    end else if (same) begin
      videoChar = {1'b1, qm[8], ~qm[7:0]};
      disp_d = disp_q + $signed({4'b0000, qm[8], 1'b0}) - bal;
    end else begin
      videoChar = {1'b0, qm[8], qm[7:0]};
      disp_d = disp_q - $signed({4'b0000, ~qm[8], 1'b0}) + bal;
    end
  end
  always_ff @(posedge pixelClock) begin
    if (!resetN || clearDisparity) disp_q <= '0;
    else disp_q <= disp_d;
  end
endmodule

// File: rtl/hdmi_period_sequencer.sv
// hdmi_period_sequencer: delays video, sync and island data by LATENCY clocks and
// selects control, preamble, guard-band, video or island characters per channel.
module hdmi_period_sequencer
  import hdmi_pkg::*;
#(
  parameter int LATENCY = PRE_LEN + GB_LEN
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       videoEnable,
  input  logic       hSync,
  input  logic       vSync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       islandActive,
  input  logic [9:0] islandCh0,
  input  logic [9:0] islandCh1,
  input  logic [9:0] islandCh2,
  output logic [9:0] tmdsCh0,
  output logic [9:0] tmdsCh1,
  output logic [9:0] tmdsCh2,
  output logic       overlapError
);
  stage_t in_s, last;
  stage_t pipe_q [1:LATENCY];
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, ctl;
  logic pend_q, pend_d, err_q, err_d;
  logic vid_rise, isl_rise, video_busy, island_busy, clear_disp;
  logic [9:0] enc0, enc1, enc2, ch0_q, ch1_q, ch2_q, ch0_d, ch1_d, ch2_d;
  assign in_s = '{de: videoEnable, hs: hSync, vs: vSync, isl: islandActive, r: red, g: green,
                  b: blue, ich0: islandCh0, ich1: islandCh1, ich2: islandCh2};
  assign last = pipe_q[LATENCY];
  assign vid_rise = videoEnable & ~pipe_q[1].de;
  assign isl_rise = islandActive & ~pipe_q[1].isl;
  assign video_busy = state_q inside {VPRE, VGB, VIDEO};
  assign island_busy = pend_q || state_q inside {IPRE, ISLAND};
  assign clear_disp = state_d != VIDEO;
  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      for (int k = 1; k <= LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[1] <= in_s;
      for (int k = 2; k <= LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end
  // pend_q marks an island whose preamble starts ISLAND_WAIT clocks after its input rise
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    err_d = err_q;
    unique case (state_q)
      CTRL:    if (pend_q && cnt_q == 4'(ISLAND_WAIT - 1)) begin
                 state_d = IPRE;
                 pend_d = 1'b0;
               end
      VPRE:    if (cnt_q == 4'(PRE_LEN - 1)) state_d = VGB;
      VGB:     if (cnt_q == 4'(GB_LEN - 1)) state_d = last.de ? VIDEO : CTRL;
      VIDEO:   if (!last.de) state_d = CTRL;
      IPRE:    if (cnt_q == 4'(PRE_LEN - 1)) state_d = last.isl ? ISLAND : CTRL;
      ISLAND:  if (!last.isl) state_d = CTRL;
      default: state_d = CTRL;
    endcase
    if (vid_rise && !video_busy) begin
      state_d = VPRE;
      pend_d = 1'b0;
      err_d = err_q | island_busy | isl_rise;
    end else if (isl_rise) begin
      err_d = err_q | video_busy | island_busy;
      pend_d = pend_q | ~(video_busy | island_busy);
    end
    cnt_d = (state_d != state_q || (pend_d && !pend_q)) ? 4'd0 : cnt_q + {3'b000, cnt_q != 4'hF};
  end
  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      state_q <= CTRL;
      cnt_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  tmds_video_encoder u_enc0 (.pixelClock(pixelClock), .resetN(resetN), .clearDisparity(clear_disp),
                             .videoData(last.b), .videoChar(enc0));
  tmds_video_encoder u_enc1 (.pixelClock(pixelClock), .resetN(resetN), .clearDisparity(clear_disp),
                             .videoData(last.g), .videoChar(enc1));
  tmds_video_encoder u_enc2 (.pixelClock(pixelClock), .resetN(resetN), .clearDisparity(clear_disp),
                             .videoData(last.r), .videoChar(enc2));
  always_comb begin
    ctl = state_d == VPRE ? VIDEO_PREAMBLE : state_d == IPRE ? ISLAND_PREAMBLE : 4'b0000;
    ch0_d = state_d == VGB ? VGB_CH0 : state_d == VIDEO ? enc0 : state_d == ISLAND ? last.ich0 :
            ctrl_code({last.vs, last.hs});
    ch1_d = state_d == VGB ? VGB_CH1 : state_d == VIDEO ? enc1 : state_d == ISLAND ? last.ich1 :
            ctrl_code(ctl[1:0]);
    ch2_d = state_d == VGB ? VGB_CH2 : state_d == VIDEO ? enc2 : state_d == ISLAND ? last.ich2 :
            ctrl_code(ctl[3:2]);
  end
  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      ch0_q <= CTRL_00;
      ch1_q <= CTRL_00;
      ch2_q <= CTRL_00;
    end else begin
      ch0_q <= ch0_d;
      ch1_q <= ch1_d;
      ch2_q <= ch2_d;
    end
  end
  assign tmdsCh0 = ch0_q;
  assign tmdsCh1 = ch1_q;
  assign tmdsCh2 = ch2_q;
  assign overlapError = err_q;
endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// tb_hdmi_period_sequencer: directed checks of preamble, guard band, video, island, overlap and reset behaviour.
module tb_hdmi_period_sequencer;
  logic pixelClock = 1'b0;
  logic resetN, videoEnable, hSync, vSync, islandActive, overlapError;
  logic [7:0] red, green, blue;
  logic [9:0] islandCh0, islandCh1, islandCh2, tmdsCh0, tmdsCh1, tmdsCh2;
  int tests = 0;
  int fails = 0;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] G0 = 10'b1011001100;
  localparam logic [9:0] G1 = 10'b0100110011;
  localparam logic [9:0] Z0 = 10'b0100000000;
  localparam logic [9:0] Z1 = 10'b1111111111;

  always #5 pixelClock = ~pixelClock;

  hdmi_period_sequencer dut (
    .pixelClock(pixelClock), .resetN(resetN), .videoEnable(videoEnable), .hSync(hSync),
    .vSync(vSync), .red(red), .green(green), .blue(blue), .islandActive(islandActive),
    .islandCh0(islandCh0), .islandCh1(islandCh1), .islandCh2(islandCh2),
    .tmdsCh0(tmdsCh0), .tmdsCh1(tmdsCh1), .tmdsCh2(tmdsCh2), .overlapError(overlapError)
  );

  task automatic tick();
    @(posedge pixelClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
    chk({tag, "_ch0"}, tmdsCh0, e0);
    chk({tag, "_ch1"}, tmdsCh1, e1);
    chk({tag, "_ch2"}, tmdsCh2, e2);
  endtask

  task automatic chk_err(input string tag, input logic exp);
    chk(tag, {9'b0, overlapError}, {9'b0, exp});
  endtask

  task automatic set_island(input logic a, input int base);
    islandActive = a;
    islandCh0 = a ? 10'(base) : '0;
    islandCh1 = a ? 10'(base + 200) : '0;
    islandCh2 = a ? 10'(base + 500) : '0;
  endtask

  initial begin
    resetN = 1'b0; videoEnable = 1'b0; hSync = 1'b1; vSync = 1'b0;
    red = '0; green = '0; blue = '0;
    set_island(1'b0, 0);
    tick(); tick();
    chk3("rst", C00, C00, C00);
    chk_err("rst_err", 1'b0);
    resetN = 1'b1;
    repeat (10) tick();
    chk("idle10_ch0", tmdsCh0, C00);
    tick();
    chk3("idle11", C01, C00, C00);
    chk_err("idle_err", 1'b0);
    // video line, black pixels, 4 clocks of DE
    for (int j = 0; j < 16; j++) begin
      videoEnable = j < 4;
      tick();
      if (j < 8) chk3($sformatf("v1_pre%0d", j), C01, C01, C00);
      else if (j < 10) chk3($sformatf("v1_gb%0d", j), G0, G1, G0);
      else if (j < 14) chk3($sformatf("v1_vid%0d", j), j % 2 == 0 ? Z0 : Z1, j % 2 == 0 ? Z0 : Z1, j % 2 == 0 ? Z0 : Z1);
      else chk3($sformatf("v1_end%0d", j), C01, C00, C00);
    end
    repeat (4) tick();
    // coloured line: disparity must restart from zero
    red = 8'h10; green = 8'h01; blue = 8'hFF;
    for (int j = 0; j < 13; j++) begin
      videoEnable = j < 2;
      tick();
      if (j == 9) chk("v2_gb_ch1", tmdsCh1, G1);
      if (j == 10) chk3("v2_px0", 10'b1000000000, 10'b0111111111, 10'b0111110000);
      if (j == 11) chk3("v2_px1", 10'b0011111111, 10'b1100000000, 10'b0111110000);
      if (j == 12) chk3("v2_end", C01, C00, C00);
    end
    red = '0; green = '0; blue = '0;
    repeat (4) tick();
    // 36-character island
    for (int j = 0; j < 48; j++) begin
      set_island(j < 36, 100 + j);
      tick();
      if (j < 2 || j >= 46) chk3($sformatf("isl_ctl%0d", j), C01, C00, C00);
      else if (j < 10) chk3($sformatf("isl_pre%0d", j), C01, C01, C01);
      else chk3($sformatf("isl_chr%0d", j), 10'(90 + j), 10'(290 + j), 10'(590 + j));
    end
    chk_err("isl_err", 1'b0);
    repeat (4) tick();
    // video and island rise together
    for (int j = 0; j < 15; j++) begin
      videoEnable = j < 3;
      set_island(j < 5, 700 + j);
      tick();
      if (j == 0) chk_err("both_err", 1'b1);
      if (j < 8) chk3($sformatf("both_pre%0d", j), C01, C01, C00);
      else if (j < 10) chk3($sformatf("both_gb%0d", j), G0, G1, G0);
      else if (j < 13) chk3($sformatf("both_vid%0d", j), j % 2 == 0 ? Z0 : Z1, j % 2 == 0 ? Z0 : Z1, j % 2 == 0 ? Z0 : Z1);
      else chk3($sformatf("both_end%0d", j), C01, C00, C00);
    end
    repeat (5) tick();
    chk_err("both_hold", 1'b1);
    // reset pulse in the middle of video
    for (int j = 0; j < 12; j++) begin
      videoEnable = 1'b1;
      tick();
      if (j == 10) chk("rv_vid", tmdsCh0, Z0);
    end
    videoEnable = 1'b0;
    resetN = 1'b0;
    tick();
    chk3("rv_rst", C00, C00, C00);
    chk_err("rv_rst_err", 1'b0);
    resetN = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk3($sformatf("rv_idle%0d", j), C00, C00, C00);
    end
    for (int j = 0; j < 14; j++) begin
      videoEnable = j < 3;
      tick();
      if (j == 0) chk("rv_pre_ch1", tmdsCh1, C01);
      if (j == 9) chk3("rv_gb", G0, G1, G0);
      if (j == 10) chk3("rv_vid0", Z0, Z0, Z0);
      if (j == 13) chk3("rv_end", C01, C00, C00);
    end
    repeat (4) tick();
    // island rises 5 clocks ahead of video and is aborted
    for (int j = 0; j < 21; j++) begin
      set_island(j < 20, 800 + j);
      videoEnable = j >= 5 && j < 8;
      tick();
      if (j == 4) chk_err("abort_err_before", 1'b0);
      if (j == 5) chk_err("abort_err_after", 1'b1);
      if (j < 2) chk3($sformatf("ab_ctl%0d", j), C01, C00, C00);
      else if (j < 5) chk3($sformatf("ab_ipre%0d", j), C01, C01, C01);
      else if (j < 13) chk3($sformatf("ab_vpre%0d", j), C01, C01, C00);
      else if (j < 15) chk3($sformatf("ab_gb%0d", j), G0, G1, G0);
      else if (j < 18) chk3($sformatf("ab_vid%0d", j), j % 2 == 1 ? Z0 : Z1, j % 2 == 1 ? Z0 : Z1, j % 2 == 1 ? Z0 : Z1);
      else chk3($sformatf("ab_end%0d", j), C01, C00, C00);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
